// File: rtl/pj_dmem_arbiter.sv
// Two-port data-memory arbiter: LSU (port 0) and DBG (port 1) share one memory interface.
// DBG is protected from starvation and may lock the memory for bursts; LSU reads flush on mispredict.
module pj_dmem_arbiter #(
  parameter int unsigned WORD_SIZE_P    = 16,
  parameter int unsigned STARVE_LIMIT_P = 8
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  input  logic                   flush_i,
  input  logic                   lsu_v_i,
  input  logic                   lsu_we_i,
  input  logic [WORD_SIZE_P-1:0] lsu_addr_i,
  input  logic [WORD_SIZE_P-1:0] lsu_data_i,
  output logic                   lsu_ready_o,
  output logic                   lsu_resp_v_o,
  output logic [WORD_SIZE_P-1:0] lsu_resp_data_o,
  input  logic                   dbg_v_i,
  input  logic                   dbg_we_i,
  input  logic [WORD_SIZE_P-1:0] dbg_addr_i,
  input  logic [WORD_SIZE_P-1:0] dbg_data_i,
  output logic                   dbg_ready_o,
  output logic                   dbg_resp_v_o,
  output logic [WORD_SIZE_P-1:0] dbg_resp_data_o,
  input  logic                   dbg_lock_i,
  output logic                   mem_w_v_o,
  output logic [WORD_SIZE_P-1:0] mem_w_addr_o,
  output logic [WORD_SIZE_P-1:0] mem_w_data_o,
  output logic                   mem_r_v_o,
  output logic [WORD_SIZE_P-1:0] mem_r_addr_o,
  input  logic [WORD_SIZE_P-1:0] mem_r_data_i
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT_P + 1);

  localparam logic [0:0] StArb     = 1'b0;
  localparam logic [0:0] StDbgLock = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
  logic            resp_lsu_q, resp_lsu_d;
  logic            resp_dbg_q, resp_dbg_d;
  logic            lsu_gnt, dbg_gnt, force_dbg;

  assign force_dbg = (starve_cnt_q == CntW'(STARVE_LIMIT_P));

  // Grants already include the valid, so at most one is ever high.
  always_comb begin
    lsu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    state_d = state_q;
    if (state_q == StDbgLock) begin
      dbg_gnt = dbg_v_i;
      if (!dbg_lock_i) state_d = StArb;
    end else begin
      lsu_gnt = lsu_v_i & ~flush_i & ~(dbg_v_i & force_dbg);
      dbg_gnt = dbg_v_i & ~lsu_gnt;
      if (dbg_gnt && dbg_lock_i) state_d = StDbgLock;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (dbg_gnt || !dbg_v_i) begin
      starve_cnt_d = '0;
    end else if (!force_dbg) begin
      starve_cnt_d = starve_cnt_q + CntW'(1);
    end
  end

  // An LSU read granted under flush never gets a tag, covering the registration-time kill.
  assign resp_lsu_d = lsu_gnt & ~lsu_we_i & ~flush_i;
  assign resp_dbg_d = dbg_gnt & ~dbg_we_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= StArb;
      starve_cnt_q <= '0;
      resp_lsu_q   <= 1'b0;
      resp_dbg_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      resp_lsu_q   <= resp_lsu_d;
      resp_dbg_q   <= resp_dbg_d;
    end
  end

  // Every output is also gated by reset so it drops the moment reset is asserted.
  always_comb begin
    mem_w_v_o    = 1'b0;
    mem_w_addr_o = '0;
    mem_w_data_o = '0;
    mem_r_v_o    = 1'b0;
    mem_r_addr_o = '0;
    if (reset_n_i) begin
      if (lsu_gnt) begin
        if (lsu_we_i) begin
          mem_w_v_o    = 1'b1;
          mem_w_addr_o = lsu_addr_i;
          mem_w_data_o = lsu_data_i;
        end else begin
          mem_r_v_o    = 1'b1;
          mem_r_addr_o = lsu_addr_i;
        end
      end else if (dbg_gnt) begin
        if (dbg_we_i) begin
          mem_w_v_o    = 1'b1;
          mem_w_addr_o = dbg_addr_i;
          mem_w_data_o = dbg_data_i;
        end else begin
          mem_r_v_o    = 1'b1;
          mem_r_addr_o = dbg_addr_i;
        end
      end
    end
  end

  assign lsu_ready_o     = reset_n_i & lsu_gnt;
  assign dbg_ready_o     = reset_n_i & dbg_gnt;
  assign lsu_resp_v_o    = reset_n_i & resp_lsu_q & ~flush_i;
  assign dbg_resp_v_o    = reset_n_i & resp_dbg_q;
  assign lsu_resp_data_o = lsu_resp_v_o ? mem_r_data_i : '0;
  assign dbg_resp_data_o = dbg_resp_v_o ? mem_r_data_i : '0;

endmodule

// File: tb/tb_pj_dmem_arbiter.sv
// Self-checking bench for pj_dmem_arbiter: directed vector table, hand-written corner sequences
// and randomized traffic compared against a rule-level reference model.
module tb_pj_dmem_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset_n, flush;
  logic        lsu_v, lsu_we, dbg_v, dbg_we, dbg_lock;
  logic [15:0] lsu_addr, lsu_data, dbg_addr, dbg_data, mem_r_data;
  logic        lsu_ready, lsu_resp_v, dbg_ready, dbg_resp_v, mem_w_v, mem_r_v;
  logic [15:0] lsu_resp_data, dbg_resp_data, mem_w_addr, mem_w_data, mem_r_addr;

  pj_dmem_arbiter #(
    .WORD_SIZE_P   (16),
    .STARVE_LIMIT_P(LIM)
  ) dut (
    .clk_i          (clk),
    .reset_n_i      (reset_n),
    .flush_i        (flush),
    .lsu_v_i        (lsu_v),
    .lsu_we_i       (lsu_we),
    .lsu_addr_i     (lsu_addr),
    .lsu_data_i     (lsu_data),
    .lsu_ready_o    (lsu_ready),
    .lsu_resp_v_o   (lsu_resp_v),
    .lsu_resp_data_o(lsu_resp_data),
    .dbg_v_i        (dbg_v),
    .dbg_we_i       (dbg_we),
    .dbg_addr_i     (dbg_addr),
    .dbg_data_i     (dbg_data),
    .dbg_ready_o    (dbg_ready),
    .dbg_resp_v_o   (dbg_resp_v),
    .dbg_resp_data_o(dbg_resp_data),
    .dbg_lock_i     (dbg_lock),
    .mem_w_v_o      (mem_w_v),
    .mem_w_addr_o   (mem_w_addr),
    .mem_w_data_o   (mem_w_data),
    .mem_r_v_o      (mem_r_v),
    .mem_r_addr_o   (mem_r_addr),
    .mem_r_data_i   (mem_r_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: ownership, starvation age and outstanding read owners.
  bit m_locked;
  int m_starve;
  bit m_tag_lsu, m_tag_dbg;
  bit e_lg, e_dg;

  function automatic logic [127:0] all_outputs();
    return {lsu_ready, lsu_resp_v, lsu_resp_data, dbg_ready, dbg_resp_v, dbg_resp_data,
            mem_w_v, mem_w_addr, mem_w_data, mem_r_v, mem_r_addr};
  endfunction

  task automatic model_clear();
    m_locked  = 0;
    m_starve  = 0;
    m_tag_lsu = 0;
    m_tag_dbg = 0;
    e_lg      = 0;
    e_dg      = 0;
  endtask

  task automatic model_eval();
    logic        w_we;
    logic [15:0] w_addr, w_data;
    logic        lr, dr;
    logic [49:0] exp_mem;
    if (m_locked) begin
      e_lg = 0;
      e_dg = dbg_v;
    end else if (lsu_v && dbg_v) begin
      e_dg = flush || (m_starve == LIM);
      e_lg = !e_dg;
    end else begin
      e_lg = lsu_v && !flush;
      e_dg = dbg_v;
    end
    w_we   = e_lg ? lsu_we   : dbg_we;
    w_addr = e_lg ? lsu_addr : dbg_addr;
    w_data = e_lg ? lsu_data : dbg_data;
    exp_mem = '0;
    if (e_lg || e_dg) begin
      if (w_we) exp_mem = {1'b1, w_addr, w_data, 1'b0, 16'h0};
      else      exp_mem = {1'b0, 16'h0, 16'h0, 1'b1, w_addr};
    end
    lr = m_tag_lsu && !flush;
    dr = m_tag_dbg;
    check("grant", {126'd0, lsu_v & lsu_ready, dbg_v & dbg_ready}, {126'd0, e_lg, e_dg});
    check("mem", {78'd0, mem_w_v, mem_w_addr, mem_w_data, mem_r_v, mem_r_addr},
          {78'd0, exp_mem});
    check("resp", {94'd0, lsu_resp_v, lsu_resp_data, dbg_resp_v, dbg_resp_data},
          {94'd0, lr, lr ? mem_r_data : 16'h0, dr, dr ? mem_r_data : 16'h0});
  endtask

  task automatic model_update();
    m_tag_lsu = e_lg && !lsu_we;
    m_tag_dbg = e_dg && !dbg_we;
    if (e_dg || !dbg_v) m_starve = 0;
    else if (m_starve < LIM) m_starve++;
    m_locked = m_locked ? dbg_lock : (e_dg && dbg_lock);
  endtask

  // Inputs change 1ns after posedge; outputs are compared at the falling edge.
  task automatic drive_eval();
    #4;
    model_eval();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; lsu_v = 0; lsu_we = 0; lsu_addr = 0; lsu_data = 0;
    dbg_v = 0; dbg_we = 0; dbg_addr = 0; dbg_data = 0; dbg_lock = 0; mem_r_data = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    idle_inputs();
    model_clear();
    #1;
    check("reset_outputs", all_outputs(), '0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  typedef struct {
    logic        lv, lwe;
    logic [15:0] la, ld;
    logic        dv, dwe;
    logic [15:0] da, dd;
    logic        lock, fl;
    logic [15:0] rd;
    logic        e_lg, e_dg, e_lr, e_dr;
    logic [15:0] e_data;
  } vec_t;

  vec_t  tbl[9];
  bit    q_owner[$];
  bit    owner;
  bit    got;
  logic  exp_lsu_g;

  initial begin
    reset_n = 0;
    idle_inputs();
    tbl[0] = '{1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0};
    tbl[1] = '{0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 16'hBEEF, 0, 0, 1, 0, 16'hBEEF};
    tbl[2] = '{1, 0, 16'h0020, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0000, 1, 0, 0, 0, 16'h0};
    tbl[3] = '{1, 0, 16'h0024, 16'h0, 1, 0, 16'h0030, 16'h0, 0, 1, 16'h1111, 0, 1, 0, 0, 16'h0};
    tbl[4] = '{0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h2222, 0, 0, 0, 1, 16'h2222};
    tbl[5] = '{1, 1, 16'h0040, 16'h5555, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 1, 0, 0, 0, 16'h0};
    tbl[6] = '{0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h3333, 0, 0, 0, 0, 16'h0};
    tbl[7] = '{1, 0, 16'h0050, 16'h0, 1, 0, 16'h0060, 16'h0, 0, 0, 16'h0, 1, 0, 0, 0, 16'h0};
    tbl[8] = '{0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h4444, 0, 0, 1, 0, 16'h4444};

    // Directed vector table.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      lsu_v = tbl[i].lv; lsu_we = tbl[i].lwe; lsu_addr = tbl[i].la; lsu_data = tbl[i].ld;
      dbg_v = tbl[i].dv; dbg_we = tbl[i].dwe; dbg_addr = tbl[i].da; dbg_data = tbl[i].dd;
      dbg_lock = tbl[i].lock; flush = tbl[i].fl; mem_r_data = tbl[i].rd;
      drive_eval();
      check($sformatf("vec%0d", i),
            {108'd0, lsu_v & lsu_ready, dbg_v & dbg_ready, lsu_resp_v, dbg_resp_v,
             lsu_resp_data | dbg_resp_data},
            {108'd0, tbl[i].e_lg, tbl[i].e_dg, tbl[i].e_lr, tbl[i].e_dr, tbl[i].e_data});
      tick();
    end

    // Starvation: DBG forced every fifth cycle with both requesters valid.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      lsu_v = 1; lsu_addr = 16'(i); dbg_v = 1; dbg_addr = 16'(16'h100 + i);
      drive_eval();
      check($sformatf("starve%0d", i + 1), {126'd0, lsu_v & lsu_ready, dbg_v & dbg_ready},
            (i % 5 == 4) ? 128'd1 : 128'd2);
      tick();
    end

    // Lock burst with LSU valid throughout.
    do_reset();
    lsu_v = 1; lsu_addr = 16'h0300;
    dbg_v = 1; dbg_we = 1; dbg_addr = 16'h0100; dbg_data = 16'h1234; dbg_lock = 1;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      drive_eval();
      got = dbg_ready;
      tick();
    end
    check("lock_write_granted", {127'd0, got}, 128'd1);
    dbg_we = 0;
    for (int k = 0; k < 3; k++) begin
      dbg_addr = 16'(16'h0101 + k);
      mem_r_data = 16'(16'hA000 + k);
      drive_eval();
      check($sformatf("lock_lsu_ready%0d", k), {127'd0, lsu_ready}, 128'd0);
      tick();
    end
    dbg_lock = 0; dbg_v = 0; mem_r_data = 16'hA003;
    drive_eval();
    check("lock_release_cycle", {127'd0, lsu_ready}, 128'd0);
    tick();
    mem_r_data = 16'h0;
    drive_eval();
    check("lock_lsu_after", {127'd0, lsu_v & lsu_ready}, 128'd1);
    tick();

    // Back-to-back alternating reads, responses checked in issue order.
    do_reset();
    q_owner.delete();
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      mem_r_data = 16'($urandom);
      if (i < 6) begin
        if (i % 2 == 0) begin lsu_v = 1; lsu_addr = 16'(16'h200 + i); end
        else begin dbg_v = 1; dbg_addr = 16'(16'h200 + i); end
      end
      drive_eval();
      if (i > 0) begin
        if (q_owner.size() == 0) begin
          check("b2b_queue", 128'd0, 128'd1);
        end else begin
          owner = q_owner.pop_front();
          check($sformatf("b2b_resp%0d", i),
                {94'd0, lsu_resp_v, lsu_resp_data, dbg_resp_v, dbg_resp_data},
                owner ? {94'd0, 1'b0, 16'h0, 1'b1, mem_r_data}
                      : {94'd0, 1'b1, mem_r_data, 1'b0, 16'h0});
        end
      end
      if (i < 6) q_owner.push_back(i % 2 == 1);
      tick();
    end

    // Reset asserted in the cycle after a read grant.
    do_reset();
    lsu_v = 1; lsu_addr = 16'h0044;
    drive_eval();
    tick();
    dbg_v = 1; dbg_addr = 16'h0055; mem_r_data = 16'hABCD;
    reset_n = 0;
    model_clear();
    #1;
    check("reset_midop", all_outputs(), '0);
    @(posedge clk);
    #1;
    idle_inputs();
    mem_r_data = 16'h7777;
    reset_n = 1;
    for (int k = 0; k < 3; k++) begin
      drive_eval();
      check($sformatf("reset_no_resp%0d", k), {126'd0, lsu_resp_v, dbg_resp_v}, 128'd0);
      tick();
    end

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      lsu_v = ($urandom_range(3) != 0); lsu_we = $urandom_range(1);
      lsu_addr = 16'($urandom); lsu_data = 16'($urandom);
      dbg_v = ($urandom_range(2) != 0); dbg_we = $urandom_range(1);
      dbg_addr = 16'($urandom); dbg_data = 16'($urandom);
      dbg_lock = ($urandom_range(7) == 0);
      flush = ($urandom_range(5) == 0);
      mem_r_data = 16'($urandom);
      drive_eval();
      tick();
    end

    exp_lsu_g = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
